// File: rtl/panel_io_ctrl.sv
// panel_io_ctrl: front-panel interface for the 8-bit CPU core.
// Synchronises and debounces panel controls, generates the CPU advance
// enable (single step or divided auto-run), stretches the panel reset,
// performs programming-mode memory writes and returns a registered debug
// snapshot that only changes between instructions.
module panel_io_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DBG_W    = 73,
  parameter int DEB_CYC  = 4,
  parameter int AUTO_DIV = 4,
  parameter int RST_HOLD = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [6+ADDR_W+DATA_W-1:0] dev_in,
  input  logic [DBG_W-1:0]           dbg_in,
  output logic [DBG_W-1:0]           dev_out,
  output logic                       cpu_clk_en,
  output logic                       cpu_reset,
  output logic                       prog_active,
  output logic                       prog_we,
  output logic [ADDR_W-1:0]          prog_addr,
  output logic [DATA_W-1:0]          prog_data
);

  localparam int IN_W   = 6 + ADDR_W + DATA_W;
  localparam int CNT_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int DIV_W  = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(AUTO_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);
  localparam logic [DBG_W-1:0]  DBG_ZERO  = DBG_W'(0);
  localparam logic [IN_W-1:0]   IN_ZERO   = IN_W'(0);

  // Control bit positions inside dev_in
  localparam int B_AUTO = 0;
  localparam int B_STEP = 1;
  localparam int B_RST  = 2;
  localparam int B_PEN  = 3;
  localparam int B_WR   = 4;
  localparam int B_AINC = 5;

  // Synchroniser stages
  logic [IN_W-1:0]   sync1_q, sync2_q;
  logic [ADDR_W-1:0] addr_sync_s;
  logic [DATA_W-1:0] data_sync_s;

  // Debounce state
  logic [5:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];

  // Registered one-cycle rising-edge events of debounced controls
  logic step_prev_q, wr_prev_q, pen_prev_q;
  logic step_rise_q, wr_rise_q, pen_rise_q;

  // Reset stretcher
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_reset_q, cpu_reset_d;

  // Run control
  logic [DIV_W-1:0] div_q, div_d, div_inc_s;
  logic             clk_en_q, clk_en_d;

  // Programming
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_base_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d, wr_fire_s;

  // Debug snapshot
  logic [DBG_W-1:0] dev_out_q, dev_out_d;

  assign addr_sync_s = sync2_q[6 +: ADDR_W];
  assign data_sync_s = sync2_q[6+ADDR_W +: DATA_W];

  // Two-flop synchroniser for every panel input bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IN_ZERO;
      sync2_q <= IN_ZERO;
    end else begin
      sync1_q <= dev_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEB_CYC consecutive differing samples
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 6'b000000;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge events are registered one stage after the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
      wr_prev_q   <= 1'b0;
      pen_prev_q  <= 1'b0;
      step_rise_q <= 1'b0;
      wr_rise_q   <= 1'b0;
      pen_rise_q  <= 1'b0;
    end else begin
      step_prev_q <= deb_q[B_STEP];
      wr_prev_q   <= deb_q[B_WR];
      pen_prev_q  <= deb_q[B_PEN];
      step_rise_q <= deb_q[B_STEP] & ~step_prev_q;
      wr_rise_q   <= deb_q[B_WR] & ~wr_prev_q;
      pen_rise_q  <= deb_q[B_PEN] & ~pen_prev_q;
    end
  end

  // Reset stretcher: follow the debounced reset, then hold RST_HOLD cycles
  always_comb begin
    hold_d      = hold_q;
    cpu_reset_d = cpu_reset_q;
    if (deb_d[B_RST]) begin
      hold_d      = HOLD_INIT;
      cpu_reset_d = 1'b1;
    end else if (hold_q != HOLD_ZERO) begin
      hold_d      = hold_q - HOLD_ONE;
      cpu_reset_d = 1'b1;
    end else begin
      hold_d      = HOLD_ZERO;
      cpu_reset_d = 1'b0;
    end
  end

  assign div_inc_s = (div_q == DIV_LAST) ? DIV_ZERO : (div_q + DIV_ONE);

  // Run control: reset beats programming beats auto-run beats single step.
  // Decisions use the next reset/programming state so no enable pulse ever
  // coincides with cpu_reset or prog_active.
  always_comb begin
    div_d    = DIV_ZERO;
    clk_en_d = 1'b0;
    if (cpu_reset_d) begin
      div_d    = DIV_ZERO;
      clk_en_d = 1'b0;
    end else if (deb_d[B_PEN]) begin
      div_d    = DIV_ZERO;
      clk_en_d = 1'b0;
    end else if (deb_q[B_AUTO]) begin
      div_d    = div_inc_s;
      clk_en_d = (div_inc_s == DIV_LAST);
    end else begin
      div_d    = DIV_ZERO;
      clk_en_d = step_rise_q;
    end
  end

  // A write fires only while programming is still active when the edge lands
  assign wr_fire_s  = wr_rise_q & deb_q[B_PEN];
  assign ptr_base_s = pen_rise_q ? addr_sync_s : ptr_q;

  // Programming write path and address pointer
  always_comb begin
    ptr_d  = ptr_base_s;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = wr_fire_s;
    if (wr_fire_s) begin
      data_d = data_sync_s;
      if (deb_q[B_AINC]) begin
        addr_d = ptr_base_s;
        ptr_d  = ptr_base_s + ADDR_ONE;
      end else begin
        addr_d = addr_sync_s;
        ptr_d  = ptr_base_s;
      end
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  // Snapshot dbg_in only between instructions, or continuously when frozen
  always_comb begin
    dev_out_d = dev_out_q;
    if (clk_en_q || deb_q[B_PEN] || cpu_reset_q) begin
      dev_out_d = dbg_in;
    end else begin
      dev_out_d = dev_out_q;
    end
  end

  // Output and control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= HOLD_INIT;
      cpu_reset_q <= 1'b1;
      div_q       <= DIV_ZERO;
      clk_en_q    <= 1'b0;
      ptr_q       <= ADDR_ZERO;
      addr_q      <= ADDR_ZERO;
      data_q      <= DATA_ZERO;
      we_q        <= 1'b0;
      dev_out_q   <= DBG_ZERO;
    end else begin
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
      div_q       <= div_d;
      clk_en_q    <= clk_en_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      dev_out_q   <= dev_out_d;
    end
  end

  assign dev_out     = dev_out_q;
  assign cpu_clk_en  = clk_en_q;
  assign cpu_reset   = cpu_reset_q;
  assign prog_active = deb_q[B_PEN];
  assign prog_we     = we_q;
  assign prog_addr   = addr_q;
  assign prog_data   = data_q;

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Directed bench for panel_io_ctrl: a table of panel-input phases with
// expected pulse/write counts, plus hand sequences for latency, auto-increment
// programming, reset stretching and asynchronous reset.
module tb_panel_io_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DBG_W  = 73;
  localparam int IN_W   = 6 + ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic [IN_W-1:0]   dev_in;
  logic [DBG_W-1:0]  dbg_in;
  logic [DBG_W-1:0]  dev_out;
  logic              cpu_clk_en, cpu_reset, prog_active, prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  int total = 0;
  int bad   = 0;

  panel_io_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBG_W(DBG_W),
    .DEB_CYC(4), .AUTO_DIV(4), .RST_HOLD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dev_in(dev_in), .dbg_in(dbg_in),
    .dev_out(dev_out), .cpu_clk_en(cpu_clk_en), .cpu_reset(cpu_reset),
    .prog_active(prog_active), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ctl;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
    int         pulses;
    int         wes;
    logic       rst;
    logic       prog;
    logic [7:0] eaddr;
    logic [7:0] edata;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: outputs are read by the caller 1 ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
    dbg_in = DBG_W'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic set_in(input logic [5:0] ctl, input logic [7:0] a, input logic [7:0] d);
    dev_in = {d, a, ctl};
  endtask

  initial begin
    int np, nw, pidx;
    logic [DBG_W-1:0] snap;
    logic [7:0] wa [8];
    logic [7:0] wd [8];
    logic [7:0] ea [3];
    logic [7:0] ed [3];

    //                ctl       addr   data  cyc pul we rst   prog  eaddr  edata
    tbl[0]  = '{6'b000000, 8'h00, 8'h00, 12, 0,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{6'b000010, 8'h00, 8'h00,  3, 0,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{6'b000000, 8'h00, 8'h00, 12, 0,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{6'b000010, 8'h00, 8'h00, 12, 1,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{6'b000000, 8'h00, 8'h00, 12, 0,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{6'b000001, 8'h00, 8'h00,  8, 0,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{6'b000001, 8'h00, 8'h00, 40, 10, 0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{6'b000011, 8'h00, 8'h00, 20, 5,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{6'b000001, 8'h00, 8'h00, 18, 5,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{6'b000000, 8'h00, 8'h00, 12, 1,  0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{6'b001000, 8'h40, 8'h5A, 12, 0,  0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[11] = '{6'b011000, 8'h41, 8'h5A, 12, 0,  1, 1'b0, 1'b1, 8'h41, 8'h5A};
    tbl[12] = '{6'b001000, 8'h41, 8'h5A, 12, 0,  0, 1'b0, 1'b1, 8'h41, 8'h5A};
    tbl[13] = '{6'b011000, 8'h10, 8'hC3, 12, 0,  1, 1'b0, 1'b1, 8'h10, 8'hC3};
    tbl[14] = '{6'b000000, 8'h10, 8'hC3, 12, 0,  0, 1'b0, 1'b0, 8'h10, 8'hC3};
    tbl[15] = '{6'b010000, 8'h77, 8'h99, 12, 0,  0, 1'b0, 1'b0, 8'h10, 8'hC3};
    tbl[16] = '{6'b000000, 8'h77, 8'h99, 12, 0,  0, 1'b0, 1'b0, 8'h10, 8'hC3};
    tbl[17] = '{6'b001010, 8'h77, 8'h99, 12, 0,  0, 1'b0, 1'b1, 8'h10, 8'hC3};
    tbl[18] = '{6'b010000, 8'h77, 8'h99, 12, 0,  0, 1'b0, 1'b0, 8'h10, 8'hC3};
    tbl[19] = '{6'b000000, 8'h00, 8'h00, 12, 0,  0, 1'b0, 1'b0, 8'h10, 8'hC3};

    // Power-on reset
    rst_n  = 1'b0;
    dev_in = '0;
    dbg_in = DBG_W'(73'h1_2345_6789_ABCD_EF01);
    repeat (3) @(posedge clk);
    #1;
    chk("rst dev_out",     128'(dev_out),     128'(0));
    chk("rst cpu_clk_en",  128'(cpu_clk_en),  128'(0));
    chk("rst cpu_reset",   128'(cpu_reset),   128'(1));
    chk("rst prog_active", 128'(prog_active), 128'(0));
    chk("rst prog_we",     128'(prog_we),     128'(0));
    chk("rst prog_addr",   128'(prog_addr),   128'(0));
    chk("rst prog_data",   128'(prog_data),   128'(0));
    rst_n = 1'b1;

    // Table-driven phases
    for (int r = 0; r < NV; r++) begin
      set_in(tbl[r].ctl, tbl[r].addr, tbl[r].data);
      np = 0;
      nw = 0;
      for (int c = 0; c < tbl[r].cyc; c++) begin
        cyc();
        if (cpu_clk_en) np++;
        if (prog_we) nw++;
      end
      chk($sformatf("row%0d pulses", r),    128'(np),          128'(tbl[r].pulses));
      chk($sformatf("row%0d writes", r),    128'(nw),          128'(tbl[r].wes));
      chk($sformatf("row%0d cpu_reset", r), 128'(cpu_reset),   128'(tbl[r].rst));
      chk($sformatf("row%0d prog", r),      128'(prog_active), 128'(tbl[r].prog));
      chk($sformatf("row%0d addr", r),      128'(prog_addr),   128'(tbl[r].eaddr));
      chk($sformatf("row%0d data", r),      128'(prog_data),   128'(tbl[r].edata));
    end

    // Step latency and snapshot: pulse 7 edges after first sampling edge
    set_in(6'b000010, 8'h00, 8'h00);
    np   = 0;
    pidx = -1;
    snap = '0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (pidx >= 0 && (i == pidx + 1 || i == pidx + 6))
        chk($sformatf("step snapshot @%0d", i), 128'(dev_out), 128'(snap));
      if (cpu_clk_en) begin
        np++;
        pidx = i;
        snap = dbg_in;
      end
    end
    chk("step pulse count",   128'(np),   128'(1));
    chk("step pulse latency", 128'(pidx), 128'(7));
    set_in(6'b000000, 8'h00, 8'h00);
    repeat (12) cyc();

    // Programming with auto-increment across the address wrap
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
    nw = 0;
    np = 0;
    set_in(6'b101000, 8'hFE, 8'h00);
    for (int i = 0; i < 12 + 3 * 24; i++) begin
      if (i >= 12 && ((i - 12) % 24) == 0) set_in(6'b111000, 8'h05, ed[(i - 12) / 24]);
      if (i >= 12 && ((i - 12) % 24) == 12) set_in(6'b101000, 8'h05, ed[(i - 12) / 24]);
      cyc();
      if (cpu_clk_en) np++;
      if (prog_we) begin
        if (nw < 8) begin
          wa[nw] = prog_addr;
          wd[nw] = prog_data;
        end
        nw++;
      end
    end
    chk("autoinc writes",   128'(nw), 128'(3));
    chk("autoinc no pulse", 128'(np), 128'(0));
    for (int k = 0; k < 3; k++) begin
      if (k < nw) begin
        chk($sformatf("autoinc addr%0d", k), 128'(wa[k]), 128'(ea[k]));
        chk($sformatf("autoinc data%0d", k), 128'(wd[k]), 128'(ed[k]));
      end
    end
    set_in(6'b000000, 8'h00, 8'h00);
    repeat (12) cyc();

    // Panel reset stretch while auto-run is requested
    set_in(6'b000001, 8'h00, 8'h00);
    repeat (13) cyc();
    set_in(6'b000101, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("press cpu_reset @%0d", i), 128'(cpu_reset), 128'(i >= 5));
      if (i >= 5) chk($sformatf("press clk_en @%0d", i), 128'(cpu_clk_en), 128'(0));
    end
    set_in(6'b000001, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk($sformatf("hold cpu_reset @%0d", i), 128'(cpu_reset), 128'(i < 8));
      chk($sformatf("hold clk_en @%0d", i),    128'(cpu_clk_en), 128'(i == 10));
    end

    // Asynchronous reset during auto-run with a write debounce in flight
    set_in(6'b011001, 8'h20, 8'hAB);
    repeat (3) cyc();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst dev_out",     128'(dev_out),     128'(0));
    chk("arst cpu_clk_en",  128'(cpu_clk_en),  128'(0));
    chk("arst cpu_reset",   128'(cpu_reset),   128'(1));
    chk("arst prog_active", 128'(prog_active), 128'(0));
    chk("arst prog_we",     128'(prog_we),     128'(0));
    chk("arst prog_addr",   128'(prog_addr),   128'(0));
    chk("arst prog_data",   128'(prog_data),   128'(0));
    set_in(6'b101000, 8'h20, 8'hAB);
    repeat (3) cyc();
    rst_n = 1'b1;
    np = 0;
    nw = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (cpu_clk_en) np++;
      if (prog_we) nw++;
    end
    chk("post-arst writes",    128'(nw),          128'(0));
    chk("post-arst pulses",    128'(np),          128'(0));
    chk("post-arst prog",      128'(prog_active), 128'(1));
    chk("post-arst cpu_reset", 128'(cpu_reset),   128'(0));
    chk("post-arst addr",      128'(prog_addr),   128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
